// File: rtl/sentry_icache_miss_arbiter_pkg.sv
// Shared types for the ICache miss arbiter and the memory manager behind it.
// A mem_req_t carries a 64 B line address plus the lane tag that steers the returned line.
package sentry_icache_miss_arbiter_pkg;

  localparam int SENTRY_WIDTH    = 4;
  localparam int MAX_OUTSTANDING = 8;
  localparam int CNT_W           = 4;
  localparam int SEQ_W           = 4;
  localparam int IDX_W           = $clog2(SENTRY_WIDTH);

  typedef struct packed {
    logic [SENTRY_WIDTH-1:0] rotate;
    logic [SEQ_W-1:0]        seq;
  } tag_t;

  typedef struct packed {
    logic [31:0] addr;
    tag_t        tag;
  } mem_req_t;

  typedef enum logic [0:0] {
    S_ARB   = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  function automatic logic [31:0] line_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:6], 6'b000000};
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(SENTRY_WIDTH - 1)) ? IDX_W'(0) : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/sentry_icache_miss_arbiter_if.sv
// Lane request, memory-request FIFO and response-observation signals of the miss arbiter.
// master is the arbiter's view, slave is the lanes / FIFO / memory-manager side.
interface sentry_icache_miss_arbiter_if;
  import sentry_icache_miss_arbiter_pkg::*;

  logic [SENTRY_WIDTH-1:0]       lane_req_valid;
  logic [SENTRY_WIDTH*32-1:0]    lane_req_addr;
  logic [SENTRY_WIDTH-1:0]       lane_req_ready;
  logic                          flush;
  mem_req_t                      mem_req_fifo_input;
  logic                          mem_req_fifo_wr_en;
  logic                          mem_req_fifo_full;
  logic                          mem_req_fifo_almost_full;
  logic [SENTRY_WIDTH-1:0]       inst_pkt2_fifo_wr_en;
  logic [SENTRY_WIDTH*CNT_W-1:0] lane_outstanding;

  modport master (
    input  lane_req_valid, lane_req_addr, flush, mem_req_fifo_full,
           mem_req_fifo_almost_full, inst_pkt2_fifo_wr_en,
    output lane_req_ready, mem_req_fifo_input, mem_req_fifo_wr_en, lane_outstanding
  );

  modport slave (
    output lane_req_valid, lane_req_addr, flush, mem_req_fifo_full,
           mem_req_fifo_almost_full, inst_pkt2_fifo_wr_en,
    input  lane_req_ready, mem_req_fifo_input, mem_req_fifo_wr_en, lane_outstanding
  );

endinterface

// File: rtl/sentry_icache_miss_arbiter_chk.sv
// Simulation-only protocol checks for the miss arbiter: no write into a full FIFO, no credit underflow.
`ifdef SIMULATION
module sentry_icache_miss_arbiter_chk
  import sentry_icache_miss_arbiter_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  input logic                    issue_i,
  input logic                    fifo_full_i,
  input logic [SENTRY_WIDTH-1:0] underflow_i
);

  a_issue_not_full: assert property (@(posedge clk) disable iff (!rst_n) !(issue_i && fifo_full_i))
    else $error("memory-request FIFO written while full");

  a_credit_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) underflow_i == '0)
    else $error("credit returned to a lane with nothing outstanding");

endmodule
`endif

// File: rtl/sentry_icache_miss_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of elig_i at or after ptr_i, wrapping.
module sentry_rr_pick
  import sentry_icache_miss_arbiter_pkg::*;
#(
  parameter int W  = SENTRY_WIDTH,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [W-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0] cand_s;

  // Scan from the farthest offset inward so the lane nearest the pointer is written last and wins.
  always_comb begin
    idx_o   = '0;
    any_o   = 1'b0;
    cand_s  = '0;
    grant_o = '0;
    for (int k = W - 1; k >= 0; k--) begin
      cand_s = {1'b0, ptr_i} + (IW+1)'(k);
      cand_s = (cand_s >= (IW+1)'(W)) ? cand_s - (IW+1)'(W) : cand_s;
      idx_o  = elig_i[cand_s[IW-1:0]] ? cand_s[IW-1:0] : idx_o;
      any_o  = any_o | elig_i[cand_s[IW-1:0]];
    end
    for (int i = 0; i < W; i++) begin
      grant_o[i] = any_o & (idx_o == IW'(i));
    end
  end

endmodule

// File: rtl/sentry_icache_miss_arbiter.sv
// Round-robin line-fill arbiter feeding the ICache memory-request FIFO, with per-lane
// in-flight credits so no lane can overrun its inst_pkt2 FIFO.
module sentry_icache_miss_arbiter
  import sentry_icache_miss_arbiter_pkg::*;
(
  input logic                          clk,
  input logic                          rst_n,
  sentry_icache_miss_arbiter_if.master bus
);

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      ptr_q, ptr_d;
  logic [IDX_W-1:0]                      lane_q, lane_d;
  logic [SENTRY_WIDTH-1:0][SEQ_W-1:0]    seq_q, seq_d;
  logic [SENTRY_WIDTH-1:0][CNT_W-1:0]    out_q, out_d;
  logic [SENTRY_WIDTH-1:0]               ready_q, ready_d;
  logic                                  wr_en_q, wr_en_d;
  mem_req_t                              req_q, req_d;

  logic [SENTRY_WIDTH-1:0][31:0]         addr_s;
  logic [SENTRY_WIDTH-1:0]               elig_s;
  logic [SENTRY_WIDTH-1:0]               grant_s;
  logic [SENTRY_WIDTH-1:0]               inc_s;
  logic [SENTRY_WIDTH-1:0]               underflow_s;
  logic [IDX_W-1:0]                      pick_idx_s;
  logic                                  pick_any_s;
  logic                                  grant_ok_s;

  assign addr_s = bus.lane_req_addr;

  // A lane competes only while it still has credit left.
  always_comb begin
    elig_s = '0;
    for (int j = 0; j < SENTRY_WIDTH; j++) begin
      elig_s[j] = bus.lane_req_valid[j] & (out_q[j] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  sentry_rr_pick #(
    .W  (SENTRY_WIDTH),
    .IW (IDX_W)
  ) u_pick (
    .elig_i  (elig_s),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  // Almost-full rather than full gates the grant, so the following write always has room.
  assign grant_ok_s = (state_q == S_ARB) & pick_any_s & ~bus.mem_req_fifo_almost_full
                      & ~bus.mem_req_fifo_full & ~bus.flush;

  // Arbitration FSM next-state and registered strobes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    seq_d   = seq_q;
    ready_d = '0;
    wr_en_d = 1'b0;
    req_d   = req_q;
    inc_s   = '0;
    case (state_q)
      S_ARB: begin
        if (grant_ok_s) begin
          state_d            = S_ISSUE;
          lane_d             = pick_idx_s;
          ready_d            = grant_s;
          wr_en_d            = 1'b1;
          req_d.addr         = line_addr(addr_s[pick_idx_s]);
          req_d.tag.rotate   = grant_s;
          req_d.tag.seq      = seq_q[pick_idx_s];
        end else begin
          state_d = S_ARB;
        end
      end
      S_ISSUE: begin
        state_d        = S_ARB;
        inc_s[lane_q]  = 1'b1;
        seq_d[lane_q]  = seq_q[lane_q] + SEQ_W'(1);
        ptr_d          = next_idx(lane_q);
      end
      default: begin
        state_d = S_ARB;
      end
    endcase
    // An issue already accepted from a lane still completes; only the ordering state restarts.
    if (bus.flush) begin
      ptr_d = '0;
      seq_d = '0;
    end else begin
      ptr_d = ptr_d;
    end
  end

  // Credit counters: issue adds one, an observed response write returns one.
  always_comb begin
    out_d       = out_q;
    underflow_s = '0;
    for (int j = 0; j < SENTRY_WIDTH; j++) begin
      underflow_s[j] = bus.inst_pkt2_fifo_wr_en[j] & ~inc_s[j] & (out_q[j] == CNT_W'(0));
      case ({inc_s[j], bus.inst_pkt2_fifo_wr_en[j]})
        2'b10:   out_d[j] = out_q[j] + CNT_W'(1);
        2'b01:   out_d[j] = underflow_s[j] ? out_q[j] : out_q[j] - CNT_W'(1);
        default: out_d[j] = out_q[j];
      endcase
    end
  end

  // All arbiter state; reset abandons any pending write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ARB;
      ptr_q   <= '0;
      lane_q  <= '0;
      seq_q   <= '0;
      out_q   <= '0;
      ready_q <= '0;
      wr_en_q <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      seq_q   <= seq_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      req_q   <= req_d;
    end
  end

  assign bus.lane_req_ready     = ready_q;
  assign bus.mem_req_fifo_wr_en = wr_en_q;
  assign bus.mem_req_fifo_input = req_q;
  assign bus.lane_outstanding   = out_q;

`ifdef SIMULATION
  sentry_icache_miss_arbiter_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_i     (state_q == S_ISSUE),
    .fifo_full_i (bus.mem_req_fifo_full),
    .underflow_i (underflow_s)
  );
`endif

endmodule

// File: tb/tb_sentry_icache_miss_arbiter.sv
// Self-checking bench for sentry_icache_miss_arbiter: directed scenarios plus a randomized run,
// all checked against a transaction-level reference model of grants, credits and sequence ids.
module tb_sentry_icache_miss_arbiter;
  import sentry_icache_miss_arbiter_pkg::*;

  localparam int W = SENTRY_WIDTH;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sentry_icache_miss_arbiter_if bus ();

  sentry_icache_miss_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a granted request is written on the following cycle, after which the
  // lane's credit and sequence id advance and the pointer moves past the granted lane.
  int       m_out [W];
  int       m_seq [W];
  int       m_ptr;
  bit       m_pend;
  int       m_lane;
  bit       m_wr;
  bit [W-1:0] m_ready;
  bit [39:0]  m_req;
  bit       g;
  int       pick;
  int       l;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < W; j++) begin
        m_out[j] = 0;
        m_seq[j] = 0;
      end
      m_ptr = 0; m_pend = 0; m_lane = 0; m_wr = 0; m_ready = '0; m_req = '0;
    end else begin
      g = 0;
      pick = 0;
      if (!m_pend && !bus.mem_req_fifo_almost_full && !bus.mem_req_fifo_full && !bus.flush) begin
        for (int k = 0; k < W; k++) begin
          l = (m_ptr + k) % W;
          if (!g && bus.lane_req_valid[l] && m_out[l] < MAX_OUTSTANDING) begin
            g = 1;
            pick = l;
          end
        end
      end
      if (g) begin
        m_req[39:8] = bus.lane_req_addr[32*pick +: 32] & 32'hFFFF_FFC0;
        m_req[7:4]  = 4'(1 << pick);
        m_req[3:0]  = 4'(m_seq[pick]);
      end
      if (m_pend) begin
        m_out[m_lane] = m_out[m_lane] + 1;
        m_seq[m_lane] = (m_seq[m_lane] + 1) % 16;
        m_ptr = (m_lane + 1) % W;
      end
      for (int j = 0; j < W; j++) begin
        if (bus.inst_pkt2_fifo_wr_en[j] && m_out[j] > 0) m_out[j] = m_out[j] - 1;
      end
      if (bus.flush) begin
        m_ptr = 0;
        for (int j = 0; j < W; j++) m_seq[j] = 0;
      end
      m_wr    = g;
      m_ready = g ? W'(1 << pick) : '0;
      m_pend  = g;
      m_lane  = pick;
    end
  end

  function automatic logic [W*CNT_W-1:0] model_out_vec();
    logic [W*CNT_W-1:0] v;
    v = '0;
    for (int j = 0; j < W; j++) v[CNT_W*j +: CNT_W] = CNT_W'(m_out[j]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.lane_req_valid           = '0;
    bus.lane_req_addr            = '0;
    bus.flush                    = 1'b0;
    bus.mem_req_fifo_full        = 1'b0;
    bus.mem_req_fifo_almost_full = 1'b0;
    bus.inst_pkt2_fifo_wr_en     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic rand_addrs();
    bus.lane_req_addr = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #7;
    n_tests++;
    if (bus.mem_req_fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.mem_req_fifo_wr_en);
    end
    n_tests++;
    if (bus.lane_req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.lane_req_ready);
    end
    n_tests++;
    if (bus.mem_req_fifo_input !== 40'h0) begin
      n_fail++; $display("FAIL reset_input: got %h want 0", bus.mem_req_fifo_input);
    end
    n_tests++;
    if (bus.lane_outstanding !== 16'h0) begin
      n_fail++; $display("FAIL reset_outstanding: got %h want 0", bus.lane_outstanding);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_lane();
    do_reset();
    bus.lane_req_valid = 4'b0100;
    bus.lane_req_addr  = {32'h0, 32'h0000_1234, 32'h0, 32'h0};
    tick();
    n_tests++;
    if (bus.mem_req_fifo_wr_en !== 1'b1 || bus.lane_req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_strobe: got wr %b rdy %b want 1 0100",
                         bus.mem_req_fifo_wr_en, bus.lane_req_ready);
    end
    n_tests++;
    if (bus.mem_req_fifo_input !== {32'h0000_1200, 4'b0100, 4'h0}) begin
      n_fail++; $display("FAIL single_req: got %h want 0000120040", bus.mem_req_fifo_input);
    end
    bus.lane_req_valid = 4'b0000;
    tick();
    n_tests++;
    if (bus.mem_req_fifo_wr_en !== 1'b0 || bus.lane_outstanding !== 16'h0100) begin
      n_fail++; $display("FAIL single_after: got wr %b out %h want 0 0100",
                         bus.mem_req_fifo_wr_en, bus.lane_outstanding);
    end
  endtask

  task automatic test_round_robin();
    int writes;
    writes = 0;
    do_reset();
    bus.lane_req_valid = 4'b1111;
    rand_addrs();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_tests++;
      if (bus.mem_req_fifo_wr_en !== m_wr || bus.mem_req_fifo_input !== m_req) begin
        n_fail++; $display("FAIL rr_model c=%0d: got wr %b req %h want %b %h",
                           c, bus.mem_req_fifo_wr_en, bus.mem_req_fifo_input, m_wr, m_req);
      end
      if (bus.mem_req_fifo_wr_en === 1'b1) begin
        n_tests++;
        if (bus.mem_req_fifo_input.tag.rotate !== 4'(1 << (writes % 4)) ||
            bus.mem_req_fifo_input.tag.seq !== 4'(writes / 4)) begin
          n_fail++; $display("FAIL rr_order w=%0d: got rot %b seq %0d want %b %0d", writes,
                             bus.mem_req_fifo_input.tag.rotate, bus.mem_req_fifo_input.tag.seq,
                             4'(1 << (writes % 4)), writes / 4);
        end
        writes++;
      end
      rand_addrs();
    end
    n_tests++;
    if (writes != 5) begin
      n_fail++; $display("FAIL rr_count: got %0d writes want 5", writes);
    end
  endtask

  task automatic test_credit_limit();
    do_reset();
    bus.lane_req_valid = 4'b0001;
    rand_addrs();
    repeat (16) tick();
    n_tests++;
    if (bus.lane_outstanding[3:0] !== 4'd8) begin
      n_fail++; $display("FAIL credit_full: got %0d want 8", bus.lane_outstanding[3:0]);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++;
      if (bus.mem_req_fifo_wr_en !== 1'b0 || bus.lane_req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL credit_block c=%0d: got wr %b rdy %b want 0 0000",
                           c, bus.mem_req_fifo_wr_en, bus.lane_req_ready);
      end
    end
    bus.inst_pkt2_fifo_wr_en = 4'b0001;
    tick();
    bus.inst_pkt2_fifo_wr_en = 4'b0000;
    n_tests++;
    if (bus.lane_outstanding[3:0] !== 4'd7) begin
      n_fail++; $display("FAIL credit_return: got %0d want 7", bus.lane_outstanding[3:0]);
    end
    tick();
    n_tests++;
    if (bus.mem_req_fifo_wr_en !== 1'b1 || bus.lane_req_ready !== 4'b0001 ||
        bus.mem_req_fifo_input !== m_req) begin
      n_fail++; $display("FAIL credit_regrant: got wr %b rdy %b req %h want 1 0001 %h",
                         bus.mem_req_fifo_wr_en, bus.lane_req_ready, bus.mem_req_fifo_input, m_req);
    end
  endtask

  task automatic test_almost_full();
    int writes;
    writes = 0;
    do_reset();
    bus.mem_req_fifo_almost_full = 1'b1;
    bus.lane_req_valid = 4'b1111;
    rand_addrs();
    repeat (10) begin
      tick();
      if (bus.mem_req_fifo_wr_en === 1'b1) writes++;
    end
    n_tests++;
    if (writes != 0) begin
      n_fail++; $display("FAIL af_block: got %0d writes want 0", writes);
    end
    bus.mem_req_fifo_almost_full = 1'b0;
    tick();
    n_tests++;
    if (bus.mem_req_fifo_wr_en !== 1'b1 || bus.mem_req_fifo_input.tag.rotate !== 4'b0001) begin
      n_fail++; $display("FAIL af_release: got wr %b rot %b want 1 0001",
                         bus.mem_req_fifo_wr_en, bus.mem_req_fifo_input.tag.rotate);
    end
  endtask

  task automatic test_same_cycle_credit();
    do_reset();
    bus.lane_req_valid = 4'b0010;
    rand_addrs();
    repeat (6) tick();
    n_tests++;
    if (bus.lane_outstanding[7:4] !== 4'd3) begin
      n_fail++; $display("FAIL same_pre: got %0d want 3", bus.lane_outstanding[7:4]);
    end
    tick();
    bus.lane_req_valid       = 4'b0000;
    bus.inst_pkt2_fifo_wr_en = 4'b0010;
    tick();
    bus.inst_pkt2_fifo_wr_en = 4'b0000;
    n_tests++;
    if (bus.lane_outstanding[7:4] !== 4'd3 || bus.lane_outstanding !== model_out_vec()) begin
      n_fail++; $display("FAIL same_cycle: got %h want lane1=3 (%h)",
                         bus.lane_outstanding, model_out_vec());
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus.lane_req_valid = 4'b1111;
    rand_addrs();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_tests++;
    if (bus.lane_outstanding !== 16'h0001) begin
      n_fail++; $display("FAIL flush_issue_done: got %h want 0001", bus.lane_outstanding);
    end
    tick();
    n_tests++;
    if (bus.mem_req_fifo_wr_en !== 1'b1 || bus.mem_req_fifo_input.tag.rotate !== 4'b0001 ||
        bus.mem_req_fifo_input.tag.seq !== 4'd0) begin
      n_fail++; $display("FAIL flush_restart: got wr %b rot %b seq %0d want 1 0001 0",
                         bus.mem_req_fifo_wr_en, bus.mem_req_fifo_input.tag.rotate,
                         bus.mem_req_fifo_input.tag.seq);
    end
    tick();
    bus.flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (bus.mem_req_fifo_wr_en !== 1'b0) begin
        n_fail++; $display("FAIL flush_arb_block c=%0d: got wr %b want 0", c, bus.mem_req_fifo_wr_en);
      end
    end
    bus.flush = 1'b0;
    tick();
    n_tests++;
    if (bus.mem_req_fifo_input.tag.rotate !== 4'b0001 || bus.mem_req_fifo_input.tag.seq !== 4'd0 ||
        bus.lane_outstanding !== 16'h0002) begin
      n_fail++; $display("FAIL flush_arb_restart: got rot %b seq %0d out %h want 0001 0 0002",
                         bus.mem_req_fifo_input.tag.rotate, bus.mem_req_fifo_input.tag.seq,
                         bus.lane_outstanding);
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    bus.lane_req_valid = 4'b1111;
    rand_addrs();
    repeat (5) tick();
    n_tests++;
    if (bus.mem_req_fifo_wr_en !== 1'b1 || bus.lane_outstanding !== 16'h0011) begin
      n_fail++; $display("FAIL midrst_pre: got wr %b out %h want 1 0011",
                         bus.mem_req_fifo_wr_en, bus.lane_outstanding);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.mem_req_fifo_wr_en !== 1'b0 || bus.lane_req_ready !== 4'b0000 ||
        bus.lane_outstanding !== 16'h0) begin
      n_fail++; $display("FAIL midrst: got wr %b rdy %b out %h want 0 0000 0",
                         bus.mem_req_fifo_wr_en, bus.lane_req_ready, bus.lane_outstanding);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.lane_req_valid           = 4'($urandom_range(0, 15));
      bus.mem_req_fifo_almost_full = ($urandom_range(0, 7) == 0);
      bus.flush                    = ($urandom_range(0, 19) == 0);
      for (int j = 0; j < W; j++) begin
        bus.inst_pkt2_fifo_wr_en[j] = (m_out[j] > 0) && ($urandom_range(0, 3) == 0);
      end
      rand_addrs();
      tick();
      n_tests++;
      if (bus.mem_req_fifo_wr_en !== m_wr || bus.lane_req_ready !== m_ready ||
          bus.lane_outstanding !== model_out_vec() ||
          (m_wr && bus.mem_req_fifo_input !== m_req)) begin
        n_fail++; $display("FAIL random c=%0d: got wr %b rdy %b out %h req %h want %b %b %h %h",
                           c, bus.mem_req_fifo_wr_en, bus.lane_req_ready, bus.lane_outstanding,
                           bus.mem_req_fifo_input, m_wr, m_ready, model_out_vec(), m_req);
      end
    end
    clear_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    clear_inputs();
    #3;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_credit_limit();
    test_almost_full();
    test_same_cycle_credit();
    test_flush();
    test_reset_mid_issue();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
